mc_control_unit: RTL and testbench

- Multicycle control FSM for the 16-bit TSC datapath.
- Sequences each instruction through fetch, decode, execute, memory and writeback states.
- Drives the ALU operation interface (`alu_func`, `branch_type`) and consumes the ALU's `bcond` result.
- Also drives the PC, instruction register, register file and memory enables, handshakes with memory via `mem_ready`, and counts retired instructions.

---
 rtl/mc_control_unit.sv | 268 ++++++++++++++++++++++++++
 tb/tb_mc_control_unit.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mc_control_unit.sv
// Multicycle control unit for the 16-bit TSC datapath.
// Steps each instruction through IF/ID/EX/MEM/WB, decodes the control word
// from the current state and IR fields, and counts retired instructions.
module mc_control_unit #(
  parameter int WORD = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [3:0]      opcode,
  input  logic [5:0]      func,
  input  logic            bcond,
  input  logic            mem_ready,
  output logic            pc_write,
  output logic            pc_write_cond,
  output logic [1:0]      pc_src,
  output logic            i_or_d,
  output logic            mem_read,
  output logic            mem_write,
  output logic            ir_write,
  output logic            reg_write,
  output logic [1:0]      reg_dst,
  output logic [1:0]      mem_to_reg,
  output logic            alu_src_a,
  output logic [2:0]      alu_src_b,
  output logic [3:0]      alu_func,
  output logic [1:0]      branch_type,
  output logic            output_active,
  output logic            is_halted,
  output logic [WORD-1:0] num_inst
);

  // Opcodes (IR[15:12])
  localparam logic [3:0] OP_ADI = 4'd4;
  localparam logic [3:0] OP_ORI = 4'd5;
  localparam logic [3:0] OP_LHI = 4'd6;
  localparam logic [3:0] OP_LWD = 4'd7;
  localparam logic [3:0] OP_SWD = 4'd8;
  localparam logic [3:0] OP_JMP = 4'd9;
  localparam logic [3:0] OP_JAL = 4'd10;
  localparam logic [3:0] OP_RT  = 4'd15;

  // R-type function field codes (IR[5:0]) beyond the ALU group 0-7
  localparam logic [5:0] FN_JPR = 6'd25;
  localparam logic [5:0] FN_JRL = 6'd26;
  localparam logic [5:0] FN_WWD = 6'd28;
  localparam logic [5:0] FN_HLT = 6'd29;

  // ALU function codes
  localparam logic [3:0] FUNC_ADD = 4'd0;
  localparam logic [3:0] FUNC_ORR = 4'd3;
  localparam logic [3:0] FUNC_ID1 = 4'd8;
  localparam logic [3:0] FUNC_ID2 = 4'd9;
  localparam logic [3:0] FUNC_BXX = 4'd10;

  // Mux selects
  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;
  localparam logic [1:0] DST_RT    = 2'b00;
  localparam logic [1:0] DST_RD    = 2'b01;
  localparam logic [1:0] DST_R2    = 2'b10;
  localparam logic [1:0] WD_ALUOUT = 2'b00;
  localparam logic [1:0] WD_MDR    = 2'b01;
  localparam logic [1:0] WD_PC     = 2'b10;
  localparam logic [2:0] SRCB_REG  = 3'b000;
  localparam logic [2:0] SRCB_ONE  = 3'b001;
  localparam logic [2:0] SRCB_SEXT = 3'b010;
  localparam logic [2:0] SRCB_ZEXT = 3'b011;
  localparam logic [2:0] SRCB_HI   = 3'b100;

  typedef enum logic [2:0] {
    S_IF   = 3'd0,
    S_ID   = 3'd1,
    S_EX   = 3'd2,
    S_MEM  = 3'd3,
    S_WB   = 3'd4,
    S_HALT = 3'd5
  } state_t;

  state_t state, state_nxt;
  logic   retire;

  // Instruction class decode from the IR fields
  logic is_rtype, is_arith, is_branch, is_jpr, is_jrl, is_wwd, is_hlt;
  logic is_jump, is_legal;

  assign is_rtype  = (opcode == OP_RT);
  assign is_arith  = is_rtype && (func[5:3] == 3'b000);
  assign is_branch = (opcode[3:2] == 2'b00);
  assign is_jpr    = is_rtype && (func == FN_JPR);
  assign is_jrl    = is_rtype && (func == FN_JRL);
  assign is_wwd    = is_rtype && (func == FN_WWD);
  assign is_hlt    = is_rtype && (func == FN_HLT);
  assign is_jump   = (opcode == OP_JMP) || (opcode == OP_JAL);
  assign is_legal  = (opcode <= OP_JAL) ||
                     (is_arith || is_jpr || is_jrl || is_wwd || is_hlt);

  // bcond gates the PC load inside the datapath via pc_write_cond; the FSM
  // itself never branches on it.
  logic unused_bcond;
  assign unused_bcond = bcond;

  // State register and retired-instruction counter
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IF;
      num_inst <= '0;
    end else begin
      state <= state_nxt;
      if (retire) num_inst <= num_inst + WORD'(1);
    end
  end

  // Next-state selection; retire marks the final cycle of an instruction
  always_comb begin
    state_nxt = state;
    retire    = 1'b0;
    case (state)
      S_IF: begin
        if (mem_ready) state_nxt = S_ID;
      end
      S_ID: begin
        if (is_jump || !is_legal) begin
          state_nxt = S_IF;
          retire    = 1'b1;
        end else if (is_hlt) begin
          state_nxt = S_HALT;
          retire    = 1'b1;
        end else begin
          state_nxt = S_EX;
        end
      end
      S_EX: begin
        if (is_branch || is_jpr || is_jrl || is_wwd) begin
          state_nxt = S_IF;
          retire    = 1'b1;
        end else if ((opcode == OP_LWD) || (opcode == OP_SWD)) begin
          state_nxt = S_MEM;
        end else begin
          state_nxt = S_WB;
        end
      end
      S_MEM: begin
        if (mem_ready) begin
          if (opcode == OP_SWD) begin
            state_nxt = S_IF;
            retire    = 1'b1;
          end else begin
            state_nxt = S_WB;
          end
        end
      end
      S_WB: begin
        state_nxt = S_IF;
        retire    = 1'b1;
      end
      S_HALT: state_nxt = S_HALT;
      default: state_nxt = S_IF;
    endcase
  end

  // Control word decode; everything is held low while reset is asserted
  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    pc_src        = PC_ALU;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    reg_write     = 1'b0;
    reg_dst       = DST_RT;
    mem_to_reg    = WD_ALUOUT;
    alu_src_a     = 1'b0;
    alu_src_b     = SRCB_REG;
    alu_func      = FUNC_ADD;
    branch_type   = 2'b00;
    output_active = 1'b0;
    is_halted     = 1'b0;
    if (!reset) begin
      case (state)
        S_IF: begin
          mem_read = 1'b1;
          i_or_d   = 1'b0;
          if (mem_ready) begin
            ir_write  = 1'b1;
            pc_write  = 1'b1;
            pc_src    = PC_ALU;
            alu_src_a = 1'b0;
            alu_src_b = SRCB_ONE;
            alu_func  = FUNC_ADD;
          end
        end
        S_ID: begin
          // PC + sext(imm8) lands in ALUOut as the branch target
          alu_src_a = 1'b0;
          alu_src_b = SRCB_SEXT;
          alu_func  = FUNC_ADD;
          if (is_jump) begin
            pc_write = 1'b1;
            pc_src   = PC_JUMP;
          end
          if (opcode == OP_JAL) begin
            reg_write  = 1'b1;
            reg_dst    = DST_R2;
            mem_to_reg = WD_PC;
          end
        end
        S_EX: begin
          alu_src_a = 1'b1;
          if (is_arith) begin
            alu_src_b = SRCB_REG;
            alu_func  = func[3:0];
          end else if (is_branch) begin
            alu_src_b     = SRCB_REG;
            alu_func      = FUNC_BXX;
            branch_type   = opcode[1:0];
            pc_write_cond = 1'b1;
            pc_src        = PC_ALUOUT;
          end else if (is_jpr || is_jrl) begin
            alu_func = FUNC_ID1;
            pc_write = 1'b1;
            pc_src   = PC_ALU;
            if (is_jrl) begin
              reg_write  = 1'b1;
              reg_dst    = DST_R2;
              mem_to_reg = WD_PC;
            end
          end else if (is_wwd) begin
            alu_func      = FUNC_ID1;
            output_active = 1'b1;
          end else if (opcode == OP_ORI) begin
            alu_src_b = SRCB_ZEXT;
            alu_func  = FUNC_ORR;
          end else if (opcode == OP_LHI) begin
            alu_src_b = SRCB_HI;
            alu_func  = FUNC_ID2;
          end else begin
            // ADI, LWD, SWD: regA + sext(imm8)
            alu_src_b = SRCB_SEXT;
            alu_func  = FUNC_ADD;
          end
        end
        S_MEM: begin
          i_or_d    = 1'b1;
          mem_read  = (opcode == OP_LWD);
          mem_write = (opcode == OP_SWD);
        end
        S_WB: begin
          reg_write = 1'b1;
          if (opcode == OP_LWD) begin
            reg_dst    = DST_RT;
            mem_to_reg = WD_MDR;
          end else if (is_rtype) begin
            reg_dst    = DST_RD;
            mem_to_reg = WD_ALUOUT;
          end else begin
            reg_dst    = DST_RT;
            mem_to_reg = WD_ALUOUT;
          end
        end
        S_HALT: is_halted = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mc_control_unit.sv
// Scoreboard bench for mc_control_unit: the stimulus side walks each
// instruction through its expected phases and queues the expected control
// word per cycle; a negedge monitor pops and compares.
module tb_mc_control_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  opcode = '0;
  logic [5:0]  func = '0;
  logic        bcond = 1'b0;
  logic        mem_ready = 1'b0;
  logic        pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
  logic        reg_write, alu_src_a, output_active, is_halted;
  logic [1:0]  pc_src, reg_dst, mem_to_reg, branch_type;
  logic [2:0]  alu_src_b;
  logic [3:0]  alu_func;
  logic [15:0] num_inst;

  mc_control_unit #(.WORD(16)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .func(func), .bcond(bcond),
    .mem_ready(mem_ready), .pc_write(pc_write), .pc_write_cond(pc_write_cond),
    .pc_src(pc_src), .i_or_d(i_or_d), .mem_read(mem_read), .mem_write(mem_write),
    .ir_write(ir_write), .reg_write(reg_write), .reg_dst(reg_dst),
    .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_func(alu_func), .branch_type(branch_type),
    .output_active(output_active), .is_halted(is_halted), .num_inst(num_inst)
  );

  always #5 clk = ~clk;

  typedef enum int {P_IF, P_ID, P_EX, P_MEM, P_WB, P_HALT, P_RST} phase_t;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic [1:0] pc_src;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic [1:0] reg_dst;
    logic [1:0] mem_to_reg;
    logic       alu_src_a;
    logic [2:0] alu_src_b;
    logic [3:0] alu_func;
    logic [1:0] branch_type;
    logic       output_active;
    logic       is_halted;
  } ctrl_t;

  typedef struct {
    ctrl_t       ctrl;
    logic [15:0] num;
    bit          chk_num;
    phase_t      tag;
  } exp_t;

  exp_t  sb[$];
  ctrl_t act;
  int    n_cmp = 0;
  int    n_err = 0;
  int    cnt = 0;
  logic [3:0] cur_op = '0;
  logic [5:0] cur_fn = '0;

  assign act = {pc_write, pc_write_cond, pc_src, i_or_d, mem_read, mem_write,
                ir_write, reg_write, reg_dst, mem_to_reg, alu_src_a, alu_src_b,
                alu_func, branch_type, output_active, is_halted};

  // ISA classification straight from the instruction tables
  function automatic bit legal(input logic [3:0] op, input logic [5:0] fn);
    if (op <= 4'd10) return 1'b1;
    if (op != 4'd15) return 1'b0;
    return (fn < 6'd8) || fn == 6'd25 || fn == 6'd26 || fn == 6'd28 || fn == 6'd29;
  endfunction

  // Expected control word for one cycle of a given phase
  function automatic ctrl_t exp_out(input phase_t p, input logic [3:0] op,
                                    input logic [5:0] fn, input bit mr);
    ctrl_t c;
    c = '0;
    case (p)
      P_IF: begin
        c.mem_read = 1;
        if (mr) begin c.ir_write = 1; c.pc_write = 1; c.alu_src_b = 3'd1; end
      end
      P_ID: begin
        c.alu_src_b = 3'd2;
        if (op == 9 || op == 10) begin c.pc_write = 1; c.pc_src = 2'd2; end
        if (op == 10) begin c.reg_write = 1; c.reg_dst = 2'd2; c.mem_to_reg = 2'd2; end
      end
      P_EX: begin
        c.alu_src_a = 1;
        if (op <= 3) begin
          c.alu_func = 4'd10; c.branch_type = op[1:0];
          c.pc_write_cond = 1; c.pc_src = 2'd1;
        end else if (op == 4 || op == 7 || op == 8) c.alu_src_b = 3'd2;
        else if (op == 5) begin c.alu_src_b = 3'd3; c.alu_func = 4'd3; end
        else if (op == 6) begin c.alu_src_b = 3'd4; c.alu_func = 4'd9; end
        else if (op == 15) begin
          if (fn < 8) c.alu_func = fn[3:0];
          else if (fn == 25) begin c.alu_func = 4'd8; c.pc_write = 1; end
          else if (fn == 26) begin
            c.alu_func = 4'd8; c.pc_write = 1;
            c.reg_write = 1; c.reg_dst = 2'd2; c.mem_to_reg = 2'd2;
          end else if (fn == 28) begin c.alu_func = 4'd8; c.output_active = 1; end
        end
      end
      P_MEM: begin
        c.i_or_d = 1;
        c.mem_read = (op == 7);
        c.mem_write = (op == 8);
      end
      P_WB: begin
        c.reg_write = 1;
        if (op == 7) c.mem_to_reg = 2'd1;
        if (op == 15) c.reg_dst = 2'd1;
      end
      P_HALT: c.is_halted = 1;
      default: c = '0;
    endcase
    return c;
  endfunction

  // One clock cycle of stimulus plus its queued expectation
  task automatic cyc(input phase_t p, input bit mr, input bit rst_v, input bit chk);
    exp_t e;
    reset = rst_v;
    mem_ready = mr;
    bcond = 1'($urandom);
    if (p == P_IF) begin
      opcode = 4'($urandom);
      func = 6'($urandom);
    end else begin
      opcode = cur_op;
      func = cur_fn;
    end
    e.ctrl = rst_v ? ctrl_t'(0) : exp_out(p, cur_op, cur_fn, mr);
    e.num = cnt[15:0];
    e.chk_num = chk;
    e.tag = p;
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic retire_one();
    cnt = (cnt + 1) & 32'hFFFF;
  endtask

  // Walk one instruction through the phases its class requires
  task automatic run_instr(input logic [3:0] op, input logic [5:0] fn,
                           input int if_wait, input int mem_wait);
    cur_op = op;
    cur_fn = fn;
    repeat (if_wait) cyc(P_IF, 1'b0, 1'b0, 1'b1);
    cyc(P_IF, 1'b1, 1'b0, 1'b1);
    cyc(P_ID, 1'($urandom), 1'b0, 1'b1);
    if (op == 9 || op == 10 || !legal(op, fn) || (op == 15 && fn == 29)) begin
      retire_one();
      return;
    end
    cyc(P_EX, 1'($urandom), 1'b0, 1'b1);
    if (op <= 3 || (op == 15 && (fn == 25 || fn == 26 || fn == 28))) begin
      retire_one();
      return;
    end
    if (op == 7 || op == 8) begin
      repeat (mem_wait) cyc(P_MEM, 1'b0, 1'b0, 1'b1);
      cyc(P_MEM, 1'b1, 1'b0, 1'b1);
      if (op == 8) begin
        retire_one();
        return;
      end
    end
    cyc(P_WB, 1'($urandom), 1'b0, 1'b1);
    retire_one();
  endtask

  // Reset cycle: control word all zero, counter clears at the edge
  task automatic reset_cycle();
    cyc(P_RST, 1'($urandom), 1'b1, 1'b1);
    cnt = 0;
  endtask

  // Monitor: compare each presented cycle against the queued expectation
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      n_cmp++;
      if (act !== e.ctrl) begin
        n_err++;
        $display("FAIL ctrl phase=%0d op=%0d fn=%0d got=%h want=%h",
                 e.tag, cur_op, cur_fn, act, e.ctrl);
      end
      if (e.chk_num) begin
        n_cmp++;
        if (num_inst !== e.num) begin
          n_err++;
          $display("FAIL num_inst phase=%0d got=%0d want=%0d", e.tag, num_inst, e.num);
        end
      end
    end
  end

  logic [5:0] rfn [12] = '{6'd0, 6'd1, 6'd2, 6'd3, 6'd4, 6'd5, 6'd6, 6'd7,
                           6'd25, 6'd26, 6'd28, 6'd40};

  initial begin
    logic [3:0] op;
    logic [5:0] fn;
    int guard;
    @(posedge clk);
    #1;
    // Power-up reset held for two cycles; counter is unknown before the first edge
    cyc(P_RST, 1'b1, 1'b1, 1'b0);
    cnt = 0;
    reset_cycle();

    // Directed: ADD, LWD with 3 stall cycles, BEQ both ways, JAL, JMP, illegal
    run_instr(4'd15, 6'd0, 0, 0);
    run_instr(4'd7, 6'd0, 0, 3);
    bcond = 1'b0;
    run_instr(4'd1, 6'd0, 0, 0);
    run_instr(4'd1, 6'd0, 0, 0);
    run_instr(4'd10, 6'd0, 0, 0);
    run_instr(4'd9, 6'd0, 2, 0);
    run_instr(4'd12, 6'd0, 0, 0);
    run_instr(4'd15, 6'd63, 0, 0);
    run_instr(4'd15, 6'd28, 0, 0);
    run_instr(4'd6, 6'd0, 0, 0);
    run_instr(4'd8, 6'd0, 1, 2);

    // Randomized instruction stream, no HLT
    for (int i = 0; i < 300; i++) begin
      op = 4'($urandom_range(0, 15));
      fn = 6'($urandom);
      if (op == 15) fn = ($urandom_range(0, 3) == 0) ? 6'($urandom) : rfn[$urandom_range(0, 11)];
      if (op == 15 && fn == 29) fn = 6'd0;
      run_instr(op, fn, $urandom_range(0, 2), $urandom_range(0, 3));
    end

    // Reset during a SWD memory stall aborts the store
    cur_op = 4'd8;
    cur_fn = 6'd0;
    cyc(P_IF, 1'b1, 1'b0, 1'b1);
    cyc(P_ID, 1'b0, 1'b0, 1'b1);
    cyc(P_EX, 1'b0, 1'b0, 1'b1);
    cyc(P_MEM, 1'b0, 1'b0, 1'b1);
    cyc(P_MEM, 1'b0, 1'b0, 1'b1);
    reset_cycle();
    run_instr(4'd4, 6'd0, 0, 0);
    run_instr(4'd15, 6'd26, 0, 0);

    // HLT: halted with a frozen counter until reset
    run_instr(4'd15, 6'd29, 1, 0);
    for (int i = 0; i < 6; i++) begin
      cur_op = 4'($urandom);
      cur_fn = 6'($urandom);
      cyc(P_HALT, 1'($urandom), 1'b0, 1'b1);
    end
    reset_cycle();
    run_instr(4'd15, 6'd3, 0, 0);
    run_instr(4'd5, 6'd0, 0, 0);

    guard = 0;
    while (sb.size() > 0 && guard < 10) begin
      @(posedge clk);
      guard++;
    end
    if (sb.size() > 0) begin
      n_err++;
      $display("FAIL drain pending=%0d want=0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
